// File: rtl/seq_div16_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface seq_div16_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] q;
  logic [15:0] r;
  logic        dz;

  modport master (output start, a, b, input busy, done, q, r, dz);
  modport slave  (input start, a, b, output busy, done, q, r, dz);
endinterface

// File: rtl/seq_div16.sv
// 16-bit unsigned restoring divider, one shift-and-subtract step per clock.
// The trial subtraction reuses the 16-bit carry-lookahead adder.
module cla (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        ci_i,
  output logic [15:0] sum_c_o,
  output logic        co_c_o
);
  localparam int unsigned WIDTH = 16;
  localparam int unsigned GRP   = 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             gg;
  logic             gp;

  // Lookahead inside each 4-bit group, group carries chained between groups.
  always_comb begin
    g  = a_i & b_i;
    p  = a_i ^ b_i;
    c  = '0;
    gg = 1'b0;
    gp = 1'b1;
    c[0] = ci_i;
    for (int k = 0; k < int'(WIDTH / GRP); k++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int j = 0; j < int'(GRP); j++) begin
        gg = g[k*GRP+j] | (p[k*GRP+j] & gg);
        gp = gp & p[k*GRP+j];
        c[k*GRP+j+1] = gg | (gp & c[k*GRP]);
      end
    end
  end

  assign sum_c_o = p ^ c[WIDTH-1:0];
  assign co_c_o  = c[WIDTH];
endmodule

module seq_div16 (
  input logic        clk,
  input logic        rst_n,
  seq_div16_if.slave dif
);
  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     trial_c;
  logic [WIDTH-1:0]   diff_c;
  logic               co_c;
  logic               no_borrow_c;
  logic [WIDTH-1:0]   step_dvd_c;
  logic [WIDTH-1:0]   step_rem_c;

  // Trial step: t = {rem, dividend msb}; t - divisor via a + ~b + 1.
  assign trial_c = {rem_q, dvd_q[WIDTH-1]};

  cla u_cla (
    .a_i     (trial_c[WIDTH-1:0]),
    .b_i     (~div_q),
    .ci_i    (1'b1),
    .sum_c_o (diff_c),
    .co_c_o  (co_c)
  );

  assign no_borrow_c = co_c | trial_c[WIDTH];
  assign step_dvd_c  = {dvd_q[WIDTH-2:0], no_borrow_c};
  assign step_rem_c  = no_borrow_c ? diff_c : trial_c[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (dif.start) begin
          if (dif.b == '0) begin
            q_d     = '1;
            r_d     = dif.a;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            dvd_d   = dif.a;
            div_d   = dif.b;
            rem_d   = '0;
            cnt_d   = '0;
            dz_d    = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        dvd_d = step_dvd_c;
        rem_d = step_rem_c;
        cnt_d = cnt_q + CNT_W'(1);
        // Results are published on the final step so they appear with done.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          q_d     = step_dvd_c;
          r_d     = step_rem_c;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign dif.busy = busy_q;
  assign dif.done = done_q;
  assign dif.q    = q_q;
  assign dif.r    = r_q;
  assign dif.dz   = dz_q;
endmodule

// File: tb/tb_seq_div16.sv
// Self-checking bench for seq_div16: vector table, handshake corner cases, random divides.
module tb_seq_div16;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_div16_if dif();
  seq_div16 dut (.clk(clk), .rst_n(rst_n), .dif(dif));

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    if (b == 16'd0) begin
      e.q = 16'hFFFF; e.r = a; e.dz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = 17;
    end
    return e;
  endfunction

  // Drive one start pulse; returns at the negedge right after the accept edge.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input exp_t e);
    @(negedge clk);
    dif.start = 1'b1;
    dif.a     = a;
    dif.b     = b;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    dif.start = 1'b0;
    chk("busy_after_accept", 32'(dif.busy), 32'd1);
  endtask

  task automatic wait_done(input int lat0, output int lat, output bit seen);
    lat  = lat0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (dif.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op(input int lat0);
    int   lat;
    bit   seen;
    exp_t e;
    logic [15:0] q_seen;
    wait_done(lat0, lat, seen);
    chk("done_seen", 32'(seen), 32'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (seen) begin
        chk("latency", 32'(lat), 32'(e.lat));
        chk("busy_in_done", 32'(dif.busy), 32'd1);
        chk("q", 32'(dif.q), 32'(e.q));
        chk("r", 32'(dif.r), 32'(e.r));
        chk("dz", 32'(dif.dz), 32'(e.dz));
        q_seen = dif.q;
        @(negedge clk);
        chk("done_one_cycle", 32'(dif.done), 32'd0);
        chk("busy_after_done", 32'(dif.busy), 32'd0);
        chk("q_hold", 32'(dif.q), 32'(q_seen));
      end
    end
  endtask

  task automatic watch_no_done(input string nm, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (dif.done) pulses++;
    end
    chk(nm, 32'(pulses), 32'd0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    exp_t e;
    int   lat;
    bit   seen;
    logic [15:0] ra, rb;

    vecs[0] = '{a:16'd100,   b:16'd7,      q:16'd14,    r:16'd2,     dz:1'b0, lat:17};
    vecs[1] = '{a:16'hFFFF,  b:16'd1,      q:16'hFFFF,  r:16'd0,     dz:1'b0, lat:17};
    vecs[2] = '{a:16'hFFFF,  b:16'h8001,   q:16'd1,     r:16'h7FFE,  dz:1'b0, lat:17};
    vecs[3] = '{a:16'h8000,  b:16'hFFFF,   q:16'd0,     r:16'h8000,  dz:1'b0, lat:17};
    vecs[4] = '{a:16'd3,     b:16'd10,     q:16'd0,     r:16'd3,     dz:1'b0, lat:17};
    vecs[5] = '{a:16'd5,     b:16'd0,      q:16'hFFFF,  r:16'd5,     dz:1'b1, lat:1};
    vecs[6] = '{a:16'd12,    b:16'd4,      q:16'd3,     r:16'd0,     dz:1'b0, lat:17};
    vecs[7] = '{a:16'd1000,  b:16'd9,      q:16'd111,   r:16'd1,     dz:1'b0, lat:17};

    rst_n = 1'b0;
    dif.start = 1'b0;
    dif.a = '0;
    dif.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(dif.busy), 32'd0);
    chk("rst_done", 32'(dif.done), 32'd0);
    chk("rst_q", 32'(dif.q), 32'd0);
    chk("rst_r", 32'(dif.r), 32'd0);
    chk("rst_dz", 32'(dif.dz), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      e = '{q:vecs[i].q, r:vecs[i].r, dz:vecs[i].dz, lat:vecs[i].lat};
      launch(vecs[i].a, vecs[i].b, e);
      finish_op(1);
    end

    // start pulsed during RUN is dropped, not queued
    launch(16'd1000, 16'd9, '{q:16'd111, r:16'd1, dz:1'b0, lat:17});
    repeat (4) @(negedge clk);
    dif.start = 1'b1; dif.a = 16'd40; dif.b = 16'd3;
    @(negedge clk);
    dif.start = 1'b0;
    finish_op(6);
    watch_no_done("ignored_start_no_done", 25);

    // start held high: back-to-back operations, 18-cycle period
    sb.push_back(model(16'd200, 16'd6));
    sb.push_back(model(16'd200, 16'd6));
    @(negedge clk);
    dif.start = 1'b1; dif.a = 16'd200; dif.b = 16'd6;
    @(negedge clk);
    wait_done(1, lat, seen);
    chk("held_first_done", 32'(seen), 32'd1);
    chk("held_first_lat", 32'(lat), 32'd17);
    e = sb.pop_front();
    chk("held_first_q", 32'(dif.q), 32'(e.q));
    chk("held_first_r", 32'(dif.r), 32'(e.r));
    @(negedge clk);
    wait_done(1, lat, seen);
    dif.start = 1'b0;
    chk("held_second_done", 32'(seen), 32'd1);
    chk("held_period", 32'(lat), 32'd18);
    e = sb.pop_front();
    chk("held_second_q", 32'(dif.q), 32'(e.q));
    chk("held_second_r", 32'(dif.r), 32'(e.r));
    @(negedge clk);
    chk("held_idle", 32'(dif.busy), 32'd0);
    @(negedge clk);
    chk("held_released_idle", 32'(dif.busy), 32'd0);

    // synchronous reset in the middle of a divide
    launch(16'd500, 16'd7, model(16'd500, 16'd7));
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(sb.pop_back());
    chk("midrst_busy", 32'(dif.busy), 32'd0);
    chk("midrst_done", 32'(dif.done), 32'd0);
    chk("midrst_q", 32'(dif.q), 32'd0);
    chk("midrst_r", 32'(dif.r), 32'd0);
    chk("midrst_dz", 32'(dif.dz), 32'd0);
    watch_no_done("midrst_no_done", 20);
    launch(16'd500, 16'd7, '{q:16'd71, r:16'd3, dz:1'b0, lat:17});
    finish_op(1);

    for (int i = 0; i < 1500; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 16'd0;
        1:       rb = 16'($urandom_range(1, 15));
        2:       rb = 16'hFFFF - 16'($urandom_range(0, 3));
        default: rb = 16'($urandom);
      endcase
      launch(ra, rb, model(ra, rb));
      finish_op(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
